word_serializer: RTL and testbench
==================================

# word_serializer

Upstream feeder for the serial pattern detector. Accepts parallel words over a ready/valid handshake into a small FIFO and shifts them out one bit per enabled cycle on `d_o`/`valid_o`, which connect directly to the detector's `d_i`/`valid_i`. An external `bit_en` strobe paces the shifting.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥2.
- `DEPTH`, 4: FIFO depth in words; must be a power of two, ≥2.
- `MSB_FIRST`, 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept; equals !full (combinational from count).
- `bit_en`  in  1  pacing strobe; one bit is emitted per cycle in which it is high while shifting.
- `d_o`  out  1  serial data, registered.
- `valid_o`  out  1  `d_o` is valid this cycle, registered.
- `word_done`  out  1  one-cycle pulse coincident with the last bit of a word, registered.
- `busy`  out  1  `(state==SHIFT) || !fifo_empty`, combinational.

## Operation
- A push occurs when `in_valid && in_ready`. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- The FSM has 2 states, IDLE and SHIFT. It holds a WIDTH-bit shift register `shreg` and a bit counter `cnt` of width clog2(WIDTH).
- IDLE:
  - If the FIFO is not empty: pop, `shreg <= head`, `cnt <= WIDTH-1`, go to SHIFT.
  - The pop is independent of `bit_en`.
  - Otherwise stay in IDLE.
- SHIFT with `bit_en=1`:
  - `d_o <=` the selected end of `shreg`, `valid_o <= 1`.
  - `shreg` shifts toward the emitted end.
  - `cnt` decrements.
- SHIFT with `bit_en=1` and `cnt==0`:
  - `word_done <= 1`.
  - If the FIFO is not empty: pop and reload `shreg`/`cnt` on the same edge and stay in SHIFT, so there is no gap between words.
  - Otherwise go to IDLE.
- SHIFT with `bit_en=0`: `valid_o <= 0` and all state holds. `d_o` holds its last value.
- Total storage is DEPTH+1 words: FIFO plus `shreg`.
- Reset values:
  - state = IDLE.
  - FIFO pointers/count = 0, so `in_ready=1` after reset.
  - `d_o=0`, `valid_o=0`, `word_done=0`.
  - `shreg=0`, `cnt=0`.
- Reset mid-word discards the FIFO contents and the partial word. No further bits are emitted. Outputs read reset values in the cycle after `rst` is sampled high.

## Timing
- Handshake in cycle T (with the FIFO empty and IDLE):
  - FIFO not empty at T+1.
  - Load into `shreg` at the T+1 edge.
  - SHIFT during T+2.
  - With `bit_en` held high, first `valid_o` at T+3 and last bit at T+WIDTH+2.
- Back-to-back words: with `bit_en` high and the next word already queued, `valid_o` stays high continuously.
- `in_ready` rises the cycle after a pop from a full FIFO.
- `word_done` is high only together with `valid_o`.

## Structure
- Shared package `serializer_pkg`:
  - state encoding `S_IDLE=1'b0`, `S_SHIFT=1'b1`;
  - default `WIDTH`/`DEPTH` constants.
- One sub-module, `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports push, pop, data in/out, full, empty, count.
- The top level holds the FSM, `shreg`, `cnt` and the output registers.

## Test plan
- Reset:
  - Drive `rst=1` mid-stream.
  - Required: next cycle `valid_o=0`, `d_o=0`, `word_done=0`, `in_ready=1`, `busy=0`.
  - After release, no stale bits are emitted.
- Single word:
  - Push 8'hA5 at T, `bit_en=1`, MSB_FIRST=1.
  - Required: `d_o`=1,0,1,0,0,1,0,1 on T+3..T+10 with `valid_o=1`.
  - Required: `word_done=1` only at T+10.
- Back-to-back:
  - Push 8'hFF then 8'h00 on consecutive cycles, `bit_en=1`.
  - Required: 16 consecutive `valid_o` cycles, 8 ones then 8 zeros.
  - Required: `word_done` pulses at bit 8 and bit 16.
- Full/backpressure:
  - Hold `bit_en=0` and present 6 words.
  - Required: exactly 5 accepted (4 in FIFO + 1 in `shreg`), `in_ready=0` on the 6th.
  - Then raise `bit_en`. Required: `in_ready` returns within 9 cycles and output order matches input order.
- Pacing:
  - Single word, toggle `bit_en` 1,0,1,0…
  - Required: `valid_o` high only in cycles following `bit_en=1`, all 8 bits delivered, no bit duplicated or skipped.
- End-to-end:
  - Drive `pattern_det` from `d_o`/`valid_o` with word 8'b0010_1000.
  - Required: the detector's `pattern` asserts once, following the 5th emitted bit (sequence 0,0,1,0,1).

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM encoding and default sizing.
package serializer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: buffers words in a FIFO and shifts them out one bit per bit_en cycle.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             d_o,
    output logic             valid_o,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t               state, state_n;
    logic [WIDTH-1:0]     shreg, shreg_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 d_n, valid_n, done_n;
    logic                 pop;
    logic [WIDTH-1:0]     head;
    logic                 full, empty;
    logic [$clog2(DEPTH):0] count;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready = !full;
    assign busy     = (state == S_SHIFT) || !empty;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        d_n     = d_o;
        valid_n = 1'b0;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    cnt_n   = CNT_LOAD;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    d_n     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                    valid_n = 1'b1;
                    shreg_n = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg[WIDTH-1:1]};
                    cnt_n   = cnt - 1'b1;
                    if (cnt == '0) begin
                        done_n = 1'b1;
                        // Reload on the last-bit edge so consecutive words leave no gap.
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_n = head;
                            cnt_n   = CNT_LOAD;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            d_o       <= 1'b0;
            valid_o   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            d_o       <= d_n;
            valid_o   <= valid_n;
            word_done <= done_n;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer with a bit-level scoreboard and a reference 00101 detector.
module tb_word_serializer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_en;
    logic             d_o;
    logic             valid_o;
    logic             word_done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic q[$];
    int   bitpos    = 0;
    int   bits_seen = 0;
    int   det_cnt   = 0;
    int   det_pos   = 0;
    logic [4:0] hist = '1;
    logic en_at_edge = 1'b0;

    word_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_en    (bit_en),
        .d_o       (d_o),
        .valid_o   (valid_o),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
    endtask

    // Drive a word for one cycle; the expected bits are queued only if the FIFO accepts it.
    task automatic offer(input logic [WIDTH-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        if (in_ready) enqueue(w);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
        tick();
    endtask

    always @(posedge clk) en_at_edge <= bit_en;

    // Scoreboard and reference detector, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            bitpos = 0;
        end else if (valid_o) begin
            check("bit_expected", 32'(q.size() > 0), 32'd1);
            check("valid_follows_en", 32'(en_at_edge), 32'd1);
            if (q.size() > 0) check("d_o", 32'(d_o), 32'(q.pop_front()));
            if (bitpos == 0) hist = '1;
            hist = {hist[3:0], d_o};
            bitpos++;
            bits_seen++;
            if (hist == 5'b00101) begin
                det_cnt++;
                det_pos = bitpos;
            end
            check("word_done", 32'(word_done), 32'(bitpos == WIDTH));
            if (bitpos == WIDTH) bitpos = 0;
        end else begin
            check("done_without_valid", 32'(word_done), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        logic [WIDTH-1:0] words [6];
        logic [WIDTH-1:0] a5;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        bit_en   = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_d", 32'(d_o), 32'd0);
        check("rst_done", 32'(word_done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single word with exact cycle timing
        bit_en = 1'b1;
        a5 = 8'hA5;
        check("single_ready", 32'(in_ready), 32'd1);
        offer(a5);
        in_valid = 1'b0;
        tick();
        check("single_T2_valid", 32'(valid_o), 32'd0);
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            check("single_valid", 32'(valid_o), 32'd1);
            check("single_bit", 32'(d_o), 32'(a5[WIDTH-1-i]));
            check("single_done", 32'(word_done), 32'(i == WIDTH - 1));
            tick();
        end
        check("single_after", 32'(valid_o), 32'd0);
        wait_idle("single_drain");

        // Back-to-back words: continuous valid
        offer(8'hFF);
        offer(8'h00);
        in_valid = 1'b0;
        n = 0;
        while (!valid_o && n < 10) begin
            tick();
            n++;
        end
        check("b2b_start", 32'(n < 10), 32'd1);
        for (int i = 0; i < 2 * WIDTH; i++) begin
            check("b2b_valid", 32'(valid_o), 32'd1);
            check("b2b_bit", 32'(d_o), 32'(i < WIDTH));
            check("b2b_done", 32'(word_done), 32'(i == WIDTH - 1 || i == 2 * WIDTH - 1));
            tick();
        end
        check("b2b_after", 32'(valid_o), 32'd0);
        wait_idle("b2b_drain");

        // Backpressure: DEPTH+1 words fit with shifting stalled
        bit_en = 1'b0;
        words = '{8'h11, 8'h92, 8'h3C, 8'hE4, 8'h5A, 8'h77};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            check("full_ready", 32'(in_ready), 32'(i < 5));
            if (in_ready) enqueue(words[i]);
            tick();
        end
        in_valid = 1'b0;
        check("full_hold", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        bit_en = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("full_ready_return", 32'(n <= 9), 32'd1);
        wait_idle("full_drain");

        // Pacing with alternating bit_en
        start = bits_seen;
        bit_en = 1'b0;
        offer(8'hC6);
        in_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bit_en = ~bit_en;
            tick();
        end
        bit_en = 1'b1;
        wait_idle("pace_drain");
        check("pace_bits", 32'(bits_seen - start), 32'd8);

        // End-to-end through the 00101 reference detector
        start = det_cnt;
        offer(8'b0010_1000);
        in_valid = 1'b0;
        wait_idle("e2e_drain");
        check("e2e_count", 32'(det_cnt - start), 32'd1);
        check("e2e_pos", 32'(det_pos), 32'd5);

        // Reset mid-stream discards everything
        offer(8'hA5);
        offer(8'h3C);
        offer(8'hF0);
        in_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        q.delete();
        tick();
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_d", 32'(d_o), 32'd0);
        check("mid_rst_done", 32'(word_done), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_quiet", 32'(valid_o), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
